// File: rtl/upc_seq_pkg.sv
// Shared types and sizes for the micro-sequencer: microword ops, FSM states, widths.
package upc_seq_pkg;

   localparam int unsigned UPC_W       = 5;
   localparam int unsigned STACK_DEPTH = 4;
   localparam int unsigned SP_W        = $clog2(STACK_DEPTH + 1);
   localparam int unsigned IDX_W       = $clog2(STACK_DEPTH);

   typedef enum logic [2:0] {
      UOP_NEXT = 3'd0,
      UOP_JUMP = 3'd1,
      UOP_BR   = 3'd2,
      UOP_CALL = 3'd3,
      UOP_RET  = 3'd4,
      UOP_DISP = 3'd5,
      UOP_WAIT = 3'd6,
      UOP_HALT = 3'd7
   } uop_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_WAIT = 2'd2
   } state_e;

endpackage

// File: rtl/upc_seq_stack.sv
// LIFO return-address stack; dout always shows the top entry, entries themselves are not reset.
module upc_seq_stack
   import upc_seq_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic             clr,
   input  logic [UPC_W-1:0] din,
   output logic [UPC_W-1:0] dout,
   output logic             full,
   output logic             empty
);

   logic [UPC_W-1:0] mem [STACK_DEPTH];
   logic [SP_W-1:0]  sp;
   logic [SP_W-1:0]  top_idx;

   assign full    = (sp == SP_W'(STACK_DEPTH));
   assign empty   = (sp == SP_W'(0));
   assign top_idx = sp - SP_W'(1);
   assign dout    = mem[top_idx[IDX_W-1:0]];

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         sp <= SP_W'(0);
      else if (clr)
         sp <= SP_W'(0);
      else if (push && !full)
         sp <= sp + SP_W'(1);
      else if (pop && !empty)
         sp <= sp - SP_W'(1);
   end

   always_ff @(posedge clk) begin
      if (push && !full && !clr)
         mem[sp[IDX_W-1:0]] <= din;
   end

endmodule

// File: rtl/upc_seq.sv
// Microprogram sequencer: drives the control-store address from the current microword op.
// Build option UPC_SEQ_STACK_EN adds the CALL/RET return stack and the sticky err fault.
module upc_seq
   import upc_seq_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       uop,
   input  logic [UPC_W-1:0] uaddr,
   input  logic [2:0]       cond_sel,
   input  logic [3:0]       cond_in,
   input  logic [UPC_W-1:0] dispatch_addr,
   input  logic             ext_ack,
   output logic [UPC_W-1:0] upc,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic             ext_req
);

   state_e           state, state_nxt;
   logic [UPC_W-1:0] upc_nxt, upc_inc;
   logic             busy_nxt, done_nxt, ext_req_nxt, cond;

   assign upc_inc = upc + UPC_W'(1);
   assign cond    = cond_in[cond_sel[1:0]] ^ cond_sel[2];

`ifdef UPC_SEQ_STACK_EN
   logic             push, pop, clr, full, empty, err_nxt;
   logic [UPC_W-1:0] dout;

   upc_seq_stack u_stack (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .clr   (clr),
      .din   (upc_inc),
      .dout  (dout),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         err <= 1'b0;
      else
         err <= err_nxt;
   end
`else
   assign err = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= ST_IDLE;
         upc     <= UPC_W'(0);
         busy    <= 1'b0;
         done    <= 1'b0;
         ext_req <= 1'b0;
      end else begin
         state   <= state_nxt;
         upc     <= upc_nxt;
         busy    <= busy_nxt;
         done    <= done_nxt;
         ext_req <= ext_req_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      upc_nxt     = upc;
      done_nxt    = 1'b0;
      ext_req_nxt = ext_req;
`ifdef UPC_SEQ_STACK_EN
      push        = 1'b0;
      pop         = 1'b0;
      clr         = 1'b0;
      err_nxt     = err;
`endif
      case (state)
         ST_IDLE: begin
            if (start) begin
               upc_nxt   = UPC_W'(0);
               state_nxt = ST_RUN;
`ifdef UPC_SEQ_STACK_EN
               clr       = 1'b1;
               err_nxt   = 1'b0;
`endif
            end
         end
         ST_RUN: begin
            case (uop_e'(uop))
               UOP_NEXT: upc_nxt = upc_inc;
               UOP_JUMP: upc_nxt = uaddr;
               UOP_BR:   upc_nxt = cond ? uaddr : upc_inc;
`ifdef UPC_SEQ_STACK_EN
               // Stack faults abort to IDLE with upc frozen at the faulting microword.
               UOP_CALL: begin
                  if (full) begin
                     err_nxt   = 1'b1;
                     state_nxt = ST_IDLE;
                  end else begin
                     push    = 1'b1;
                     upc_nxt = uaddr;
                  end
               end
               UOP_RET: begin
                  if (empty) begin
                     err_nxt   = 1'b1;
                     state_nxt = ST_IDLE;
                  end else begin
                     pop     = 1'b1;
                     upc_nxt = dout;
                  end
               end
`else
               UOP_CALL: upc_nxt = uaddr;
               UOP_RET:  upc_nxt = upc_inc;
`endif
               UOP_DISP: upc_nxt = dispatch_addr;
               UOP_WAIT: begin
                  ext_req_nxt = 1'b1;
                  state_nxt   = ST_WAIT;
               end
               UOP_HALT: begin
                  done_nxt  = 1'b1;
                  state_nxt = ST_IDLE;
`ifdef UPC_SEQ_STACK_EN
                  clr       = 1'b1;
`endif
               end
               default: state_nxt = ST_IDLE;
            endcase
         end
         ST_WAIT: begin
            if (ext_ack) begin
               ext_req_nxt = 1'b0;
               upc_nxt     = upc_inc;
               state_nxt   = ST_RUN;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
      busy_nxt = (state_nxt != ST_IDLE);
   end

endmodule
